// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch unit.
package fetch_pkg;
  localparam int unsigned PC_W       = 16;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned IMEM_BYTES = 128;
  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect/advance/hold next-pc selection and
// a sticky flag for misaligned redirect targets.
module fetch_pc_reg #(
  parameter int unsigned     PC_W     = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_o,
  output logic            misalign_o
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
      if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (advance_i) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;
endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: drives the combinational ROM, captures one word per cycle
// into a valid/ready output register. Optional counters: FETCH_PERF_EN.
module instr_fetch #(
  parameter int unsigned     PC_W       = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(fetch_pkg::RESET_PC),
  parameter int unsigned     IMEM_BYTES = fetch_pkg::IMEM_BYTES,
  parameter logic [31:0]     NOP_WORD   = fetch_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] im_pc,
  input  logic [31:0]     im_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic            err_misalign,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [15:0]     perf_redirects,
  output logic            err_oob
`else
  output logic            err_oob
`endif
);
  import fetch_pkg::*;

  fetch_state_e        state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]  out_instr_q, out_instr_d;
  logic [PC_W-1:0]     out_pc_q, out_pc_d;
  logic                err_oob_q, err_oob_d;
  logic [PC_W-1:0]     pc;
  logic                redirect_en, capture, oob;

  // Redirects are ignored only during the post-reset boot cycle; halt freezes
  // capture immediately, not one cycle later when the state catches up.
  assign redirect_en = redirect_valid && (state_q != BOOT);
  assign capture     = (state_q == RUN) && !halt && !redirect_en &&
                       (!out_valid_q || out_ready);
  assign oob         = 32'(pc) >= IMEM_BYTES;

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_en),
    .redirect_pc_i (redirect_pc),
    .advance_i     (capture),
    .pc_o          (pc),
    .misalign_o    (err_misalign)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    err_oob_d   = err_oob_q;
    if (redirect_en) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      out_instr_d = oob ? NOP_WORD : im_instr;
      out_pc_d    = pc;
      if (oob) err_oob_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_WORD;
      out_pc_q    <= RESET_PC;
      err_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      err_oob_q   <= err_oob_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [15:0] perf_redirects_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (capture)     perf_fetched_q   <= perf_fetched_q + 32'd1;
      if (redirect_en) perf_redirects_q <= perf_redirects_q + 16'd1;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`else
`endif

  assign im_pc     = pc;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign err_oob   = err_oob_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst, out_ready, redirect_valid, halt;
  logic [15:0] redirect_pc, im_pc, out_pc;
  logic [31:0] im_instr, out_instr;
  logic        out_valid, err_misalign, err_oob;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [31:0] rom [32];

  // Model state: plain integers following the fetch rules.
  int          m_pc, m_st, m_opc;
  bit          m_valid, m_mis, m_oob;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    if (a < 16'd128) return rom[a[6:2]];
    return {16'hBAD0, a};
  endfunction

  always_comb im_instr = rom_word(im_pc);

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .im_pc          (im_pc),
    .im_instr       (im_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .err_misalign   (err_misalign),
    .err_oob        (err_oob)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_st = M_BOOT; m_valid = 0; m_instr = NOP; m_opc = 0;
      m_mis = 0; m_oob = 0;
    end else begin
      bit redir, take;
      redir = redirect_valid && (m_st != M_BOOT);
      take  = (m_st == M_RUN) && !halt && !redir && (!m_valid || out_ready);
      if (take) begin
        m_opc   = m_pc;
        m_instr = (m_pc >= 128) ? NOP : rom_word(16'(m_pc));
        if (m_pc >= 128) m_oob = 1;
        m_valid = 1;
        m_pc    = (m_pc + 4) % 65536;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (redir) begin
        m_valid = 0;
        m_pc    = int'(redirect_pc) - (int'(redirect_pc) % 4);
        if (int'(redirect_pc) % 4 != 0) m_mis = 1;
      end
      if (m_st == M_BOOT) m_st = M_RUN;
      else m_st = halt ? M_HALT : M_RUN;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_im_pc",     32'(im_pc),        32'(m_pc));
      check("model_valid",     32'(out_valid),    32'(m_valid));
      check("model_instr",     out_instr,         m_instr);
      check("model_out_pc",    32'(out_pc),       32'(m_opc));
      check("model_misalign",  32'(err_misalign), 32'(m_mis));
      check("model_oob",       32'(err_oob),      32'(m_oob));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [15:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    rom[0] = 32'h0030_0413;
    rom[1] = 32'h0034_0413;
    step(); step();
    cmp_en = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, NOP);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_errs", {30'd0, err_misalign, err_oob}, 32'd0);
    rst = 1'b0;

    step();
    check("boot_bubble", 32'(out_valid), 32'd0);
    step();
    check("first_pc", 32'(out_pc), 32'h0);
    check("first_instr", out_instr, 32'h0030_0413);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_out_pc", 32'(out_pc), 32'h0);
      check("stall_im_pc", 32'(im_pc), 32'h4);
    end
    out_ready = 1'b1;
    step();
    check("second_pc", 32'(out_pc), 32'h4);
    check("second_instr", out_instr, 32'h0034_0413);
    step();
    check("third_pc", 32'(out_pc), 32'h8);

    redirect_to(16'h0010);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_im_pc", 32'(im_pc), 32'h10);
    step();
    check("target_pc", 32'(out_pc), 32'h10);
    check("target_valid", 32'(out_valid), 32'd1);

    redirect_to(16'h0016);
    check("misalign_pc", 32'(im_pc), 32'h14);
    check("misalign_flag", 32'(err_misalign), 32'd1);
    step(); step(); step();
    check("misalign_sticky", 32'(err_misalign), 32'd1);

    redirect_to(16'h007C);
    step();
    check("last_in_bounds", 32'(out_pc), 32'h7C);
    check("oob_clear_before", 32'(err_oob), 32'd0);
    step();
    check("oob_pc", 32'(out_pc), 32'h80);
    check("oob_nop", out_instr, NOP);
    check("oob_flag", 32'(err_oob), 32'd1);

    redirect_to(16'hFFFC);
    step();
    check("wrap_out_pc", 32'(out_pc), 32'hFFFC);
    check("wrap_im_pc", 32'(im_pc), 32'h0);

    halt = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("halt_rst_valid", 32'(out_valid), 32'd0);
    check("halt_rst_pc", 32'(out_pc), 32'd0);
    check("halt_rst_instr", out_instr, NOP);
    check("halt_rst_errs", {30'd0, err_misalign, err_oob}, 32'd0);
    step(); step();
    halt = 1'b0;
    step();
    check("restart_idle", 32'(out_valid), 32'd0);
    step();
    check("restart_pc", 32'(out_pc), 32'h0);
    check("restart_instr", out_instr, 32'h0030_0413);

    for (int c = 0; c < 3000; c++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                   : 16'($urandom_range(0, 16'hA0));
      rst            = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end fetch unit: the initiator side of the instruction-memory read interface.
- Owns the program counter, drives the byte address `im_pc` to the combinational instruction ROM, and captures the returned word `im_instr` the same cycle.
- Presents captured instruction + PC to decode over a valid/ready handshake; accepts branch/jump redirects from execute.
- Sits between the instruction ROM and the decode stage.

Parameters:
- PC_W, 16, PC / `im_pc` width in bits (byte address).
- RESET_PC, 16'h0000, PC loaded on reset.
- IMEM_BYTES, 128, populated ROM span in bytes; fetch at PC >= IMEM_BYTES is out-of-bounds.
- NOP_WORD, 32'h00000013, word injected on out-of-bounds fetch (`addi x0,x0,0`).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- im_pc  out  PC_W  byte address to instruction ROM; combinationally equals internal pc.
- im_instr  in  32  ROM read data; valid the same cycle as `im_pc` (combinational ROM).
- out_valid  out  1  `out_instr`/`out_pc` hold a valid fetched instruction.
- out_ready  in  1  decode accepts; transfer occurs when `out_valid && out_ready`.
- out_instr  out  32  fetched instruction.
- out_pc  out  PC_W  address of `out_instr`.
- redirect_valid  in  1  execute requests PC change (taken branch/jal/jalr).
- redirect_pc  in  PC_W  redirect target.
- halt  in  1  level; freezes fetch while high.
- err_misalign  out  1  sticky: a redirect target had `pc[1:0]` != 0.
- err_oob  out  1  sticky: a fetch occurred at PC >= IMEM_BYTES.

Behaviour:
- Reset (`rst`=1 at the edge):
  - pc=RESET_PC, state=BOOT, out_valid=0, out_instr=NOP_WORD, out_pc=RESET_PC, err_misalign=0, err_oob=0.
  - A reset mid-flight discards any held instruction or pending redirect.
- States:
  - BOOT: one idle cycle after reset; no capture; next state RUN.
  - RUN: normal fetch.
  - HALTED: no capture and pc frozen; out_valid is held (a pending output still drains via `out_ready`).
- Transitions:
  - RUN -> HALTED when `halt`=1.
  - HALTED -> RUN when `halt`=0.
  - `redirect_valid` in any non-BOOT state still applies, including HALTED.
- Fetch, in RUN when `(!out_valid || out_ready)` and no redirect:
  - out_instr <= (pc >= IMEM_BYTES) ? NOP_WORD : im_instr.
  - out_pc <= pc; out_valid <= 1; pc <= pc + 4.
- Stall: if `out_valid && !out_ready`, all outputs and pc hold unchanged.
- Redirect, highest priority after rst:
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}; out_valid <= 0 (flush); no capture that cycle.
  - First instruction from the target appears on out_valid the following cycle, i.e. one bubble.
  - If `redirect_pc[1:0]` != 0, err_misalign <= 1.
- Simultaneous redirect + transfer: the handshake completes (decode consumes the old word) and the flush applies.
- Simultaneous redirect + halt: pc updates and state goes to HALTED.
- Arithmetic: pc + 4 wraps modulo 2^PC_W (0xFFFC -> 0x0000). Low two pc bits are always 0.
- err_oob is set on the capture cycle of any out-of-bounds fetch. Both error flags are cleared only by rst.
- Throughput: 1 instruction/cycle with out_ready tied high.
- Latency: `im_pc` -> `out_instr` is 1 cycle.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs `perf_fetched` [31:0] and `perf_redirects` [15:0].
  - `perf_fetched` increments on each capture.
  - `perf_redirects` increments on each applied redirect.
  - Both counters wrap, and reset to 0 on rst.
- FETCH_PERF_EN not defined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package `fetch_pkg`: NOP_WORD, RESET_PC, PC_W, the state enum (BOOT, RUN, HALTED), and the instruction-width constant 32.
- One natural sub-module, `fetch_pc_reg`: pc register plus next-pc mux. Priority order: rst, then redirect, then advance, then hold. Also produces the misalign flag.
- The handshake register and the state machine stay in the top module.

Test Plan:
- Reset then out_ready=1, ROM with 0x00300413 @0 and 0x00340413 @4 -> cycle after BOOT: out_pc=0, out_instr=0x00300413; next cycle: out_pc=4, out_instr=0x00340413.
- out_ready=0 for 3 cycles after the first valid -> out_valid=1, out_pc=0 and `im_pc`=4 all stable; out_ready=1 resumes in order.
- Redirect to 0x0010 while out_pc=8 is valid -> next cycle out_valid=0; the following cycle out_pc=0x10; pc=0x0C is never emitted.
- redirect_pc=0x0016 -> pc=0x0014 and err_misalign=1; the flag stays 1 until rst.
- Advance past 0x007C with IMEM_BYTES=128 -> out_pc=0x80, out_instr=0x00000013, err_oob=1. Separately, pc=0xFFFC wraps to 0x0000.
- halt=1 for 4 cycles mid-stream, with rst asserted on cycle 2 -> all outputs return to reset values; after halt drops, fetch restarts at RESET_PC after BOOT.
